// File: rtl/dram_axi_responder.sv
// rtl/dram_axi_responder.sv - AXI4-Lite DRAM responder, one transaction at a time with counter-modelled latency
// Optional address checking (SLVERR on out-of-range or unaligned access) enabled by defining DRAM_ERR_CHECK_EN.
module dram_axi_responder #(
  parameter int                ADDR_W = 17,
  parameter int                DATA_W = 64,
  parameter logic [ADDR_W-1:0] BASE   = 17'h10000,
  parameter int                DEPTH  = 256,
  parameter int                LAT    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              AR_VALID,
  input  logic [ADDR_W-1:0] AR_ADDR,
  output logic              AR_READY,
  output logic              R_VALID,
  output logic [DATA_W-1:0] R_DATA,
  output logic [1:0]        R_RESP,
  input  logic              R_READY,
  input  logic              AW_VALID,
  input  logic [ADDR_W-1:0] AW_ADDR,
  output logic              AW_READY,
  input  logic              W_VALID,
  input  logic [DATA_W-1:0] W_DATA,
  output logic              W_READY,
  output logic              B_VALID,
  output logic [1:0]        B_RESP,
  input  logic              B_READY
);

  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [3:0] LAT_LOAD = 4'(LAT - 1);
  localparam logic [1:0] OKAY     = 2'b00;
  localparam logic [1:0] SLVERR   = 2'b10;

  typedef enum logic [2:0] {IDLE, RD_LAT, RD_RESP, WR_DATA, WR_LAT, WR_RESP} stateType;

  stateType          state;
  stateType          nextState;
  logic [3:0]        latCnt;
  logic [IDX_W-1:0]  idxQ;
  logic [IDX_W-1:0]  selIdx;
  logic              errQ;
  logic              selErr;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] mem [DEPTH];

  // A read wins a simultaneous AR/AW, so the address to decode follows AR_VALID.
  assign selAddr = AR_VALID ? AR_ADDR : AW_ADDR;
  assign selIdx  = IDX_W'((selAddr - BASE) >> 3);

`ifdef DRAM_ERR_CHECK_EN
  localparam int              LIM_W = ADDR_W + 1;
  localparam logic [LIM_W-1:0] LIMIT = {1'b0, BASE} + LIM_W'(8 * DEPTH);
  assign selErr = (selAddr < BASE) || ({1'b0, selAddr} >= LIMIT) || (selAddr[2:0] != 3'b000);
`else
  assign selErr = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    AR_READY  = 1'b0;
    AW_READY  = 1'b0;
    W_READY   = 1'b0;
    case (state)
      IDLE: begin
        AR_READY = 1'b1;
        AW_READY = !AR_VALID;
        if (AR_VALID)      nextState = RD_LAT;
        else if (AW_VALID) nextState = WR_DATA;
      end
      RD_LAT:  if (latCnt == 4'd0) nextState = RD_RESP;
      RD_RESP: if (R_READY)        nextState = IDLE;
      WR_DATA: begin
        W_READY = 1'b1;
        if (W_VALID) nextState = WR_LAT;
      end
      WR_LAT:  if (latCnt == 4'd0) nextState = WR_RESP;
      WR_RESP: if (B_READY)        nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latCnt  <= 4'd0;
      idxQ    <= '0;
      errQ    <= 1'b0;
      R_VALID <= 1'b0;
      R_DATA  <= '0;
      R_RESP  <= OKAY;
      B_VALID <= 1'b0;
      B_RESP  <= OKAY;
    end else begin
      if (state == IDLE && (AR_VALID || AW_VALID)) begin
        idxQ <= selIdx;
        errQ <= selErr;
      end

      if ((state == IDLE && AR_VALID) || (state == WR_DATA && W_VALID))
        latCnt <= LAT_LOAD;
      else if ((state == RD_LAT || state == WR_LAT) && latCnt != 4'd0)
        latCnt <= latCnt - 4'd1;

      if (state == RD_LAT && latCnt == 4'd0) begin
        R_VALID <= 1'b1;
        R_DATA  <= errQ ? '0 : mem[idxQ];
        R_RESP  <= errQ ? SLVERR : OKAY;
      end else if (state == RD_RESP && R_READY) begin
        R_VALID <= 1'b0;
      end

      if (state == WR_LAT && latCnt == 4'd0) begin
        B_VALID <= 1'b1;
        B_RESP  <= errQ ? SLVERR : OKAY;
      end else if (state == WR_RESP && B_READY) begin
        B_VALID <= 1'b0;
      end
    end
  end

  // Storage is deliberately unreset so contents survive a reset; a write commits at the W handshake.
  always_ff @(posedge clk) begin
    if (state == WR_DATA && W_VALID && !errQ) mem[idxQ] <= W_DATA;
  end

endmodule

// File: tb/tb_dram_axi_responder.sv
// tb/tb_dram_axi_responder.sv - self-checking bench for dram_axi_responder (LAT=4 main instance, LAT=1 timing instance)
`timescale 1ns/1ps
module tb_dram_axi_responder;

  localparam int          LAT   = 4;
  localparam logic [16:0] BASE  = 17'h10000;
  localparam int          DEPTH = 256;
`ifdef DRAM_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        arValid, arReady, rValid, rReady, awValid, awReady, wValid, wReady, bValid, bReady;
  logic [16:0] arAddr, awAddr;
  logic [63:0] rData, wData;
  logic [1:0]  rResp, bResp;

  logic        arValid1, arReady1, rValid1, awReady1, wReady1, bValid1;
  logic [63:0] rData1;
  logic [1:0]  rResp1, bResp1;

  dram_axi_responder dut (
    .clk(clk), .rst_n(rst_n),
    .AR_VALID(arValid), .AR_ADDR(arAddr), .AR_READY(arReady),
    .R_VALID(rValid), .R_DATA(rData), .R_RESP(rResp), .R_READY(rReady),
    .AW_VALID(awValid), .AW_ADDR(awAddr), .AW_READY(awReady),
    .W_VALID(wValid), .W_DATA(wData), .W_READY(wReady),
    .B_VALID(bValid), .B_RESP(bResp), .B_READY(bReady)
  );

  dram_axi_responder #(.LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .AR_VALID(arValid1), .AR_ADDR(BASE), .AR_READY(arReady1),
    .R_VALID(rValid1), .R_DATA(rData1), .R_RESP(rResp1), .R_READY(1'b1),
    .AW_VALID(1'b0), .AW_ADDR(BASE), .AW_READY(awReady1),
    .W_VALID(1'b0), .W_DATA(64'd0), .W_READY(wReady1),
    .B_VALID(bValid1), .B_RESP(bResp1), .B_READY(1'b0)
  );

  int passCnt  = 0;
  int totalCnt = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    totalCnt++;
    if (got === exp) passCnt++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, exp, $time);
  endtask

  // Transaction-level model: a pending response becomes visible LAT edges after its accepting handshake.
  int          cyc = 0;
  logic [63:0] mMem [DEPTH];
  bit          mRd, mWr, mWantW, mErr;
  int          mIdx, respAt;
  logic [63:0] mRData;
  logic [1:0]  mRResp, mBResp;
  bit          pIdle, pRv, pBv, dErr;
  int          dIdx;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void decode(input logic [16:0] a, output bit err, output int idx);
    logic [16:0] off;
    off = a - BASE;
    idx = int'(off >> 3) % DEPTH;
    err = ERR_EN && ((a < BASE) || (int'(a) >= int'(BASE) + 8 * DEPTH) || (a[2:0] != 3'b000));
  endfunction

  wire eArReady = !(mRd || mWr || mWantW);
  wire eAwReady = eArReady && !arValid;
  wire eRValid  = mRd && (cyc >= respAt);
  wire eBValid  = mWr && (cyc >= respAt);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mRd = 0; mWr = 0; mWantW = 0;
    end else begin
      pIdle = !(mRd || mWr || mWantW);
      pRv   = mRd && (cyc >= respAt);
      pBv   = mWr && (cyc >= respAt);
      if (pRv && rReady) mRd = 0;
      if (pBv && bReady) mWr = 0;
      if (mWantW && wValid) begin
        mWantW = 0; mWr = 1; respAt = cyc + 1 + LAT;
        if (!mErr) mMem[mIdx] = wData;
        mBResp = mErr ? 2'b10 : 2'b00;
      end
      if (pIdle && arValid) begin
        decode(arAddr, dErr, dIdx);
        mRd = 1; respAt = cyc + 1 + LAT;
        mRData = dErr ? 64'd0 : mMem[dIdx];
        mRResp = dErr ? 2'b10 : 2'b00;
      end else if (pIdle && awValid) begin
        decode(awAddr, mErr, mIdx);
        mWantW = 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("AR_READY", arReady, eArReady);
    chk("AW_READY", awReady, eAwReady);
    chk("W_READY", wReady, mWantW);
    chk("R_VALID", rValid, eRValid);
    chk("B_VALID", bValid, eBValid);
    if (eRValid) begin
      chk("R_DATA", rData, mRData);
      chk("R_RESP", rResp, mRResp);
    end
    if (eBValid) chk("B_RESP", bResp, mBResp);
  end

  task automatic waitSig(input int which, output bit ok);
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      case (which)
        0:       ok = arReady;
        1:       ok = awReady;
        2:       ok = wReady;
        3:       ok = rValid;
        default: ok = bValid;
      endcase
    end
    if (!ok) begin
      totalCnt++;
      $display("FAIL wait%0d: signal not seen within 40 cycles", which);
    end
  endtask

  task automatic doRead(input logic [16:0] a, output logic [63:0] d, output logic [1:0] rs, output int lat);
    int t0; bit ok;
    arAddr = a; arValid = 1; rReady = 1;
    waitSig(0, ok); @(posedge clk); #1; arValid = 0; t0 = cyc;
    waitSig(3, ok); lat = cyc - t0; d = rData; rs = rResp;
    @(posedge clk); #1; rReady = 0;
  endtask

  task automatic doWrite(input logic [16:0] a, input logic [63:0] d, output logic [1:0] rs, output int lat);
    int t0; bit ok;
    awAddr = a; awValid = 1;
    waitSig(1, ok); @(posedge clk); #1; awValid = 0; wData = d; wValid = 1;
    waitSig(2, ok); @(posedge clk); #1; wValid = 0; t0 = cyc; bReady = 1;
    waitSig(4, ok); lat = cyc - t0; rs = bResp;
    @(posedge clk); #1; bReady = 0;
  endtask

  initial begin
    logic [63:0] d;
    logic [1:0]  rs;
    int          lat, t0;
    bit          ok;
    arValid = 0; arAddr = BASE; rReady = 0; awValid = 0; awAddr = BASE;
    wValid = 0; wData = 64'd0; bReady = 0; arValid1 = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset R_VALID", rValid, 0);
    chk("reset B_VALID", bValid, 0);
    chk("reset R_DATA", rData, 0);
    chk("reset R_RESP", rResp, 0);
    chk("reset B_RESP", bResp, 0);
    chk("reset W_READY", wReady, 0);
    chk("reset AR_READY", arReady, 1);
    chk("reset AW_READY", awReady, 1);
    @(posedge clk); #1; rst_n = 1;

    doWrite(17'h10008, 64'hDEAD_BEEF_0123_4567, rs, lat);
    chk("wr B latency", lat, 4);
    chk("wr B_RESP", rs, 0);
    doRead(17'h10008, d, rs, lat);
    chk("rd R latency", lat, 4);
    chk("rd R_DATA", d, 64'hDEAD_BEEF_0123_4567);
    chk("rd R_RESP", rs, 0);

    // Simultaneous AR/AW: read of old word 0 first, then the write proceeds.
    doWrite(17'h10000, 64'h1111_1111_1111_1111, rs, lat);
    arAddr = 17'h10000; awAddr = 17'h10000; wData = 64'h2222_2222_2222_2222;
    arValid = 1; awValid = 1; wValid = 1; rReady = 1;
    @(negedge clk);
    chk("sim AR_READY", arReady, 1);
    chk("sim AW_READY", awReady, 0);
    @(posedge clk); #1; arValid = 0; t0 = cyc;
    waitSig(3, ok);
    chk("sim R latency", cyc - t0, 4);
    chk("sim R_DATA old", rData, 64'h1111_1111_1111_1111);
    @(posedge clk); #1; rReady = 0;
    waitSig(1, ok); @(posedge clk); #1; awValid = 0;
    waitSig(2, ok); @(posedge clk); #1; wValid = 0; bReady = 1;
    waitSig(4, ok);
    chk("sim B_RESP", bResp, 0);
    @(posedge clk); #1; bReady = 0;
    doRead(17'h10000, d, rs, lat);
    chk("sim readback", d, 64'h2222_2222_2222_2222);

    // Ten-cycle R_READY stall.
    arAddr = 17'h10008; arValid = 1; rReady = 0;
    waitSig(0, ok); @(posedge clk); #1; arValid = 0;
    waitSig(3, ok);
    for (int i = 0; i < 10; i++) begin
      chk("stall R_VALID", rValid, 1);
      chk("stall R_DATA", rData, 64'hDEAD_BEEF_0123_4567);
      @(posedge clk); #1;
      @(negedge clk);
    end
    @(posedge clk); #1; rReady = 1;
    @(posedge clk); #1; rReady = 0;
    @(negedge clk);
    chk("stall single beat", rValid, 0);

    // Out-of-range / unaligned: SLVERR when checking, modulo wrap otherwise.
    doRead(17'h10004, d, rs, lat);
    chk("unaligned R_DATA", d, ERR_EN ? 64'd0 : 64'h2222_2222_2222_2222);
    chk("unaligned R_RESP", rs, ERR_EN ? 2'b10 : 2'b00);
    doRead(17'h10800, d, rs, lat);
    chk("high R_DATA", d, ERR_EN ? 64'd0 : 64'h2222_2222_2222_2222);
    chk("high R_RESP", rs, ERR_EN ? 2'b10 : 2'b00);
    chk("high R latency", lat, 4);
    doWrite(17'h0FFF8, 64'h0BAD_0BAD_0BAD_0BAD, rs, lat);
    chk("low B_RESP", rs, ERR_EN ? 2'b10 : 2'b00);
    chk("low B latency", lat, 4);
    doRead(17'h10000, d, rs, lat);
    chk("word0 unchanged", d, 64'h2222_2222_2222_2222);

    // Reset during WR_LAT: response dropped, write committed.
    awAddr = 17'h10010; awValid = 1;
    waitSig(1, ok); @(posedge clk); #1; awValid = 0; wData = 64'h1; wValid = 1;
    waitSig(2, ok); @(posedge clk); #1; wValid = 0; bReady = 1;
    @(posedge clk); #1; rst_n = 0;
    repeat (2) @(posedge clk); #1; rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rst no B_VALID", bValid, 0);
    end
    @(posedge clk); #1; bReady = 0;
    doRead(17'h10010, d, rs, lat);
    chk("rst write kept", d, 64'h1);

    // LAT=1 instance: held AR_VALID and R_READY give an AR accept every third cycle.
    @(posedge clk); #1; arValid1 = 1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("lat1 AR_READY", arReady1, (k % 3) == 0);
      chk("lat1 R_VALID", rValid1, (k % 3) == 2);
      chk("lat1 AW_READY", awReady1, 0);
      chk("lat1 W_READY", wReady1, 0);
      chk("lat1 B_VALID", bValid1, 0);
      if ((k % 3) == 2) chk("lat1 R_RESP", {rResp1, bResp1}, 4'b0000);
    end
    @(posedge clk); #1; arValid1 = 0;

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/dram_axi_responder.md
# dram_axi_responder

Synthesizable AXI4-Lite memory responder: the slave end of the bridge's DRAM port. It accepts one read or write transaction at a time, models DRAM access latency with a counter, and returns data/response with full VALID/READY handshakes. Used in place of the behavioural DRAM model for gate-level co-simulation and in FPGA bring-up of bridge and farm.

## Interface
- ADDR_W, 17, AXI address width (byte address)
- DATA_W, 64, data word width; one beat = 8 bytes
- BASE, 17'h10000, byte address of word 0
- DEPTH, 256, number of DATA_W words stored
- LAT, 4, cycles from address/data acceptance to response VALID (legal 1..15)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- AR_VALID / AR_ADDR  in  1 / ADDR_W  read address channel
- AR_READY  out  1  read address accept
- R_VALID / R_DATA / R_RESP  out  1 / DATA_W / 2  read data channel
- R_READY  in  1  read data accept
- AW_VALID / AW_ADDR  in  1 / ADDR_W  write address channel
- AW_READY  out  1  write address accept
- W_VALID / W_DATA  in  1 / DATA_W  write data channel
- W_READY  out  1  write data accept
- B_VALID / B_RESP  out  1 / 2  write response channel
- B_READY  in  1  write response accept

## Operation
- FSM states: IDLE, RD_LAT, RD_RESP, WR_DATA, WR_LAT, WR_RESP.
- IDLE: AR_READY=1; AW_READY=1 only when AR_VALID=0 (read wins simultaneous AR/AW). AR handshake -> latch index, load counter LAT-1 -> RD_LAT. AW handshake -> latch index -> WR_DATA.
- RD_LAT: counter decrements; at 0 -> RD_RESP with R_DATA=mem[idx], R_VALID=1.
- RD_RESP: R_VALID, R_DATA, R_RESP held stable until R_READY=1; then -> IDLE (R_VALID low next cycle).
- WR_DATA: W_READY=1; W handshake writes mem[idx]=W_DATA (if no error), loads counter LAT-1 -> WR_LAT.
- WR_LAT -> WR_RESP same as read path; B_VALID/B_RESP held until B_READY.
- Index = (ADDR - BASE) >> 3, width clog2(DEPTH).
- W_VALID arriving before/with AW is not accepted until WR_DATA (W_READY=0 elsewhere).
- Only one transaction outstanding; read-after-write always returns new data.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE, counter 0, R_VALID=B_VALID=0, R_DATA=0, R_RESP=B_RESP=0, W_READY=0; AR_READY/AW_READY combinational from state (1 in IDLE). Memory array not reset; contents survive reset.
- Reset mid-transaction: transaction dropped, no response issued; a write already past W handshake remains committed.
- AR handshake at edge t -> R_VALID first high in cycle t+LAT. Earliest next AR accept: cycle after R handshake.
- W handshake at edge t -> B_VALID high in cycle t+LAT.
- LAT=1: RD_LAT/WR_LAT occupied for exactly one cycle.
- R_READY/B_READY already high when VALID rises: one-cycle response beat.

## Configuration
- DRAM_ERR_CHECK_EN defined: address outside [BASE, BASE+8*DEPTH) or ADDR[2:0]!=0 -> R_RESP/B_RESP=2'b10 (SLVERR), R_DATA=0, memory untouched; latency unchanged.
- Undefined: no checking; index taken from low bits of (ADDR-BASE)>>3 (wraps modulo DEPTH); responses always 2'b00.

## Test plan
- Write 64'hDEAD_BEEF_0123_4567 to 17'h10008, read back 17'h10008 -> B_RESP=0 at W+4, R_DATA=64'hDEAD_BEEF_0123_4567, R_RESP=0 at AR+4.
- AR_VALID and AW_VALID both high in IDLE (addr 17'h10000) -> AR accepted, AW_READY=0 until read response completes, then write proceeds.
- R_READY held low 10 cycles after R_VALID -> R_VALID/R_DATA stable all 10 cycles, single transfer on R_READY.
- With DRAM_ERR_CHECK_EN: read 17'h10004 and 17'h10800 -> R_RESP=2'b10, R_DATA=0; write to 17'h0FFF8 -> B_RESP=2'b10, later read of word 0 unchanged.
- rst_n low during WR_LAT after writing 64'h1 to 17'h10010 -> no B_VALID; after reset, read 17'h10010 returns 64'h1.
- LAT=1 build: back-to-back reads with R_READY=1 -> AR accepted every 3 cycles, R_VALID 1 cycle after each AR.
